clk_freq_monitor: RTL and testbench

CLK_FREQ_MONITOR -- requirements
Module: clk_freq_monitor

---
 rtl/clk_freq_monitor.sv | 160 ++++++++++++++++
 tb/tb_clk_freq_monitor.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor: counts rising edges of an asynchronous clk_in over a
// fixed window of WINDOW_CYCLES system clocks and flags the result.
//
// Ports:
//   clock        system clock, all state on its rising edge
//   reset        asynchronous active-high reset
//   clk_in       monitored clock, sampled as data
//   start        request one measurement (level, sampled in IDLE)
//   busy         high while a window is being measured
//   result_valid one-cycle pulse when a new result is presented
//   edge_count   edges counted in the last completed window
//   in_range     MIN_COUNT <= edge_count <= MAX_COUNT and no overflow
//   overflow     last window saturated the edge counter
//
// Build option: define CLK_FREQ_MONITOR_CONTINUOUS_EN to run windows
// back-to-back after the first start instead of single-shot.
module clk_freq_monitor #(
    parameter int unsigned WINDOW_CYCLES = 1000,
    parameter int unsigned COUNT_WIDTH   = 16,
    parameter int unsigned MIN_COUNT     = 95,
    parameter int unsigned MAX_COUNT     = 105
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clk_in,
    input  logic                   start,
    output logic                   busy,
    output logic                   result_valid,
    output logic [COUNT_WIDTH-1:0] edge_count,
    output logic                   in_range,
    output logic                   overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        REPORT  = 2'd2
    } state_t;

    localparam logic [23:0] WIN_LAST = 24'(WINDOW_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    state_t state;
    state_t state_nxt;

    logic                   sync1;
    logic                   sync2;
    logic                   sync3;
    logic [2:0]             arm;
    logic                   edge_det;
    logic [23:0]            win_cnt;
    logic [COUNT_WIDTH-1:0] cnt;
    logic                   cnt_ovf;
    logic                   win_done;
    logic                   clear;
    logic [31:0]            cnt_ext;
    logic                   cnt_in_lim;

    // arm[2] marks that sync3 holds a genuine sample of clk_in rather than
    // its reset value, so a clk_in already high at reset release is not
    // mistaken for a rising edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            arm   <= 3'b000;
        end else begin
            sync1 <= clk_in;
            sync2 <= sync1;
            sync3 <= sync2;
            arm   <= {arm[1:0], 1'b1};
        end
    end

    assign edge_det = sync2 & ~sync3 & arm[2];
    assign win_done = (state == MEASURE) && (win_cnt == WIN_LAST);

    // Counters restart on every entry into MEASURE.
    assign clear = ((state == IDLE) && start) || (state == REPORT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (win_done) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
`ifdef CLK_FREQ_MONITOR_CONTINUOUS_EN
                state_nxt = MEASURE;
`else
                state_nxt = IDLE;
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_cnt <= '0;
            cnt     <= '0;
            cnt_ovf <= 1'b0;
        end else if (clear) begin
            win_cnt <= '0;
            cnt     <= '0;
            cnt_ovf <= 1'b0;
        end else if (state == MEASURE) begin
            win_cnt <= win_cnt + 24'd1;
            if (edge_det) begin
                // Saturate rather than wrap.
                if (cnt == CNT_MAX) begin
                    cnt_ovf <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end
    end

    assign cnt_ext    = 32'(cnt);
    assign cnt_in_lim = (cnt_ext >= MIN_COUNT) && (cnt_ext <= MAX_COUNT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_valid <= 1'b0;
            edge_count   <= '0;
            in_range     <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            result_valid <= (state == REPORT);
            if (state == REPORT) begin
                edge_count <= cnt;
                overflow   <= cnt_ovf;
                in_range   <= cnt_in_lim & ~cnt_ovf;
            end
        end
    end

    assign busy = (state == MEASURE);

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Testbench for clk_freq_monitor: drives a cycle-accurate clk_in pattern
// and checks results against an edge count taken from the driven pattern.
`timescale 1ps/100fs
module tb_clk_freq_monitor;

    localparam int W = 1000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clk_in = 1'b0;
    logic        start = 1'b0;
    logic        busy, rv, ir, ov;
    logic [15:0] ec;
    logic        busy4, rv4, ir4, ov4;
    logic [3:0]  ec4;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // b[n] = clk_in value present at posedge number n
    bit b [0:65535];

    bit gen_run = 1'b0;
    bit gen_lvl = 1'b0;
    int gen_h = 5;
    int gen_ph = 0;
    int gen_left = -1;

    clk_freq_monitor #(
        .WINDOW_CYCLES(W), .COUNT_WIDTH(16),
        .MIN_COUNT(95), .MAX_COUNT(105)
    ) u_dut (
        .clock(clock), .reset(reset), .clk_in(clk_in), .start(start),
        .busy(busy), .result_valid(rv), .edge_count(ec),
        .in_range(ir), .overflow(ov)
    );

    clk_freq_monitor #(
        .WINDOW_CYCLES(W), .COUNT_WIDTH(4),
        .MIN_COUNT(95), .MAX_COUNT(105)
    ) u_dut4 (
        .clock(clock), .reset(reset), .clk_in(clk_in), .start(start),
        .busy(busy4), .result_valid(rv4), .edge_count(ec4),
        .in_range(ir4), .overflow(ov4)
    );

    always #1 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clock);
        if (gen_run) begin
            gen_ph++;
            if (gen_ph >= gen_h) begin
                gen_ph = 0;
                if (gen_lvl) begin
                    gen_lvl = 1'b0;
                end else if (gen_left != 0) begin
                    gen_lvl = 1'b1;
                    if (gen_left > 0) gen_left--;
                end
            end
        end
        clk_in = gen_lvl;
        b[cyc + 1] = gen_lvl;
    endtask

    // Rising transitions of the driven clk_in among positions lo..hi
    function automatic int model_count(int lo, int hi);
        int c = 0;
        for (int m = lo; m <= hi; m++) begin
            if (b[m] && !b[m - 1]) c++;
        end
        return c;
    endfunction

    task automatic do_window(output int s, output int lat);
        tick();
        start = 1'b1;
        s = cyc + 1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int i = 0; i < W + 20; i++) begin
            if (rv === 1'b1) begin
                lat = cyc - s;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if ({busy, rv, ec, ir, ov} !== 20'd0) begin
            fails++;
            $display("FAIL reset_main got %h want 0", {busy, rv, ec, ir, ov});
        end
        tests++;
        if ({busy4, rv4, ec4, ir4, ov4} !== 8'd0) begin
            fails++;
            $display("FAIL reset_w4 got %h want 0", {busy4, rv4, ec4, ir4, ov4});
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        tests++;
        if ({busy, rv} !== 2'b00) begin
            fails++;
            $display("FAIL idle_after_reset got %b want 00", {busy, rv});
        end
    endtask

    task automatic test_random();
        int s, lat, exp, e4;
        for (int k = 0; k < 4; k++) begin
            gen_h = $urandom_range(2, 15);
            gen_ph = $urandom_range(0, gen_h - 1);
            gen_lvl = 1'($urandom_range(0, 1));
            gen_left = -1;
            gen_run = 1'b1;
            for (int i = $urandom_range(1, 20); i > 0; i--) tick();
            do_window(s, lat);
            exp = model_count(s - 1, s + W - 2);
            e4 = (exp > 15) ? 15 : exp;
            tests++;
            if (lat !== W + 1) begin
                fails++;
                $display("FAIL rand_latency got %0d want %0d", lat, W + 1);
            end
            tests++;
            if (ec !== 16'(exp)) begin
                fails++;
                $display("FAIL rand_count h=%0d got %0d want %0d", gen_h, ec, exp);
            end
            tests++;
            if (ir !== ((exp >= 95 && exp <= 105) ? 1'b1 : 1'b0) || ov !== 1'b0) begin
                fails++;
                $display("FAIL rand_flags got ir=%b ov=%b want count %0d", ir, ov, exp);
            end
            tests++;
            if (ec4 !== 4'(e4) || ov4 !== (exp > 15) || ir4 !== 1'b0) begin
                fails++;
                $display("FAIL rand_w4 got %0d/%b/%b want %0d/%b/0", ec4, ov4, ir4, e4, exp > 15);
            end
            tick();
            tests++;
            if (rv !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL rand_pulse got rv=%b busy=%b want 0 0", rv, busy);
            end
            for (int i = 0; i < 10; i++) tick();
            tests++;
            if (ec !== 16'(exp)) begin
                fails++;
                $display("FAIL rand_hold got %0d want %0d", ec, exp);
            end
        end
    endtask

    task automatic test_stuck();
        int s, lat;
        gen_run = 1'b0;
        gen_lvl = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        do_window(s, lat);
        tests++;
        if (lat !== W + 1 || ec !== 16'd0 || ir !== 1'b0) begin
            fails++;
            $display("FAIL stuck_low got lat=%0d cnt=%0d ir=%b want %0d 0 0", lat, ec, ir, W + 1);
        end
        // clk_in high across reset must not yield a false edge
        gen_lvl = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        do_window(s, lat);
        tests++;
        if (lat !== W + 1 || ec !== 16'(model_count(s - 1, s + W - 2))) begin
            fails++;
            $display("FAIL stuck_high got lat=%0d cnt=%0d want %0d 0", lat, ec, W + 1);
        end
    endtask

    task automatic test_boundaries();
        int s, lat, exp;
        int n [4] = '{94, 95, 105, 106};
        for (int k = 0; k < 4; k++) begin
            gen_run = 1'b0;
            gen_lvl = 1'b0;
            for (int i = 0; i < 5; i++) tick();
            gen_h = 3;
            gen_ph = 0;
            gen_left = n[k];
            gen_run = 1'b1;
            do_window(s, lat);
            exp = model_count(s - 1, s + W - 2);
            tests++;
            if (ec !== 16'(exp) || ir !== ((exp >= 95 && exp <= 105) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("FAIL boundary_%0d got cnt=%0d ir=%b want %0d", n[k], ec, ir, exp);
            end
        end
    endtask

    task automatic test_overflow();
        int s, lat, exp;
        gen_h = 4;
        gen_ph = 0;
        gen_left = -1;
        gen_run = 1'b1;
        do_window(s, lat);
        exp = model_count(s - 1, s + W - 2);
        tests++;
        if (ec4 !== 4'd15 || ov4 !== 1'b1 || ir4 !== 1'b0) begin
            fails++;
            $display("FAIL overflow_w4 got %0d/%b/%b want 15/1/0", ec4, ov4, ir4);
        end
        tests++;
        if (ec !== 16'(exp) || ov !== 1'b0 || ir !== 1'b0) begin
            fails++;
            $display("FAIL overflow_main got %0d/%b/%b want %0d/0/0", ec, ov, ir, exp);
        end
    endtask

    task automatic test_start_held();
        int s, s2, lat, pulses, busy_hi, busy_late, exp;
        gen_h = 5;
        gen_left = -1;
        gen_run = 1'b1;
        pulses = 0;
        busy_hi = 0;
        busy_late = 0;
        tick();
        start = 1'b1;
        s = cyc + 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (busy === 1'b1) busy_hi++;
            if (rv === 1'b1) pulses++;
        end
        start = 1'b0;
        for (int i = 0; i < W + 20 && cyc < s + W; i++) begin
            tick();
            if (rv === 1'b1) pulses++;
        end
        // now in the REPORT cycle: this start must be dropped
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (rv !== 1'b1) begin
            fails++;
            $display("FAIL held_latency got rv=%b at cycle %0d want 1", rv, cyc - s);
        end
        if (rv === 1'b1) pulses++;
        exp = model_count(s - 1, s + W - 2);
        tests++;
        if (ec !== 16'(exp)) begin
            fails++;
            $display("FAIL held_count got %0d want %0d", ec, exp);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy === 1'b1) busy_late++;
            if (rv === 1'b1) pulses++;
        end
        tests++;
        if (busy_hi !== 300) begin
            fails++;
            $display("FAIL held_busy got %0d want 300", busy_hi);
        end
        tests++;
        if (pulses !== 1 || busy_late !== 0) begin
            fails++;
            $display("FAIL held_single got pulses=%0d busy=%0d want 1 0", pulses, busy_late);
        end
        do_window(s2, lat);
        exp = model_count(s2 - 1, s2 + W - 2);
        tests++;
        if (lat !== W + 1 || ec !== 16'(exp)) begin
            fails++;
            $display("FAIL held_second got lat=%0d cnt=%0d want %0d %0d", lat, ec, W + 1, exp);
        end
    endtask

    task automatic test_reset_mid();
        int s, lat, pulses, exp;
        gen_h = 5;
        gen_left = -1;
        gen_run = 1'b1;
        tick();
        start = 1'b1;
        s = cyc + 1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 499; i++) tick();
        reset = 1'b1;
        #0.4;
        tests++;
        if ({busy, rv, ec, ir, ov} !== 20'd0) begin
            fails++;
            $display("FAIL midreset_main got %h want 0", {busy, rv, ec, ir, ov});
        end
        tests++;
        if ({busy4, rv4, ec4, ir4, ov4} !== 8'd0) begin
            fails++;
            $display("FAIL midreset_w4 got %h want 0", {busy4, rv4, ec4, ir4, ov4});
        end
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < W + 20; i++) begin
            tick();
            if (rv === 1'b1 || busy === 1'b1) pulses++;
        end
        tests++;
        if (pulses !== 0) begin
            fails++;
            $display("FAIL midreset_quiet got %0d active cycles want 0", pulses);
        end
        do_window(s, lat);
        exp = model_count(s - 1, s + W - 2);
        tests++;
        if (lat !== W + 1 || ec !== 16'(exp)) begin
            fails++;
            $display("FAIL midreset_new got lat=%0d cnt=%0d want %0d %0d", lat, ec, W + 1, exp);
        end
    endtask

    task automatic test_continuous();
        int s, seen, lo, exp;
        gen_h = $urandom_range(4, 6);
        gen_ph = 0;
        gen_left = -1;
        gen_run = 1'b1;
        tick();
        start = 1'b1;
        s = cyc + 1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            seen = -1;
            for (int i = 0; i < W + 20; i++) begin
                if (rv === 1'b1) begin
                    seen = cyc;
                    break;
                end
                tick();
            end
            lo = s - 1 + k * (W + 1);
            exp = model_count(lo, lo + W - 1);
            tests++;
            if (seen !== s + W + 1 + k * (W + 1)) begin
                fails++;
                $display("FAIL cont_time_%0d got %0d want %0d", k, seen, s + W + 1 + k * (W + 1));
            end
            tests++;
            if (ec !== 16'(exp) || busy !== 1'b1) begin
                fails++;
                $display("FAIL cont_count_%0d got %0d busy=%b want %0d 1", k, ec, busy, exp);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
`ifdef CLK_FREQ_MONITOR_CONTINUOUS_EN
        test_continuous();
`else
        test_random();
        test_stuck();
        test_boundaries();
        test_overflow();
        test_start_held();
        test_reset_mid();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
